// File: rtl/de0_nano_system_sense_i2c_data_pkg.sv
// ---------------------------------------------------------------------------
// de0_nano_system_sense_i2c_data_pkg
//
// Purpose:
//   Shared constants for the DE0-Nano system-sense PIO family. The input PIO,
//   the output PIOs and the bench all use these values.
//
// Contents:
//   ADDR_*  word addresses of the Avalon-MM register map
//   EDGE_*  encodings for the EDGE_TYPE parameter of the input PIO
// ---------------------------------------------------------------------------
package de0_nano_system_sense_i2c_data_pkg;

  // Register word addresses
  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_RESERVED = 2'd1;
  localparam logic [1:0] ADDR_IRQMASK  = 2'd2;
  localparam logic [1:0] ADDR_EDGECAP  = 2'd3;

  // Edge-capture selection
  localparam int EDGE_RISING  = 0;
  localparam int EDGE_FALLING = 1;
  localparam int EDGE_ANY     = 2;

endpackage

// File: rtl/de0_nano_system_sense_debounce.sv
// ---------------------------------------------------------------------------
// de0_nano_system_sense_debounce
//
// Purpose:
//   Single-bit input conditioner: a 2-flop synchronizer followed by a
//   counter-based debounce filter. A change on the synchronized pin is only
//   accepted after it has been stable for DEBOUNCE_CYCLES consecutive cycles.
//   With DEBOUNCE_CYCLES = 0 the filter is a plain register stage.
//
// Ports:
//   clk       system clock
//   reset_n   asynchronous active-low reset
//   pin       asynchronous external pin
//   filtered  debounced, clock-domain-safe pin value
// ---------------------------------------------------------------------------
module de0_nano_system_sense_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic filtered
);

  logic sync_meta;
  logic sync_out;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_out  <= 1'b0;
    end else begin
      sync_meta <= pin;
      sync_out  <= sync_meta;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          filtered <= 1'b0;
        end else begin
          filtered <= sync_out;
        end
      end

    end else begin : g_filter

      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] count;

      // The counter measures how long the synchronized value has disagreed
      // with the accepted value; any agreement restarts the measurement, so
      // a glitch shorter than DEBOUNCE_CYCLES never reaches the output.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          count    <= '0;
          filtered <= 1'b0;
        end else if (sync_out == filtered) begin
          count <= '0;
        end else if (count == LAST) begin
          filtered <= sync_out;
          count    <= '0;
        end else begin
          count <= count + CW'(1);
        end
      end

    end
  endgenerate

endmodule

// File: rtl/de0_nano_system_sense_i2c_data.sv
// ---------------------------------------------------------------------------
// de0_nano_system_sense_i2c_data
//
// Purpose:
//   Avalon-MM parallel input port. Pins are synchronized and debounced, then
//   selected edges are latched in a sticky edge-capture register that drives
//   a maskable level interrupt.
//
// Register map (word address):
//   0 DATA         RO   filtered pin value, zero-extended
//   1 reserved          reads 0, writes ignored
//   2 IRQMASK      RW   interrupt enable per pin
//   3 EDGECAPTURE  R/W1C sticky edge flags
//
// Ports:
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     register word select
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data (bits above WIDTH ignored)
//   in_port     asynchronous external pins
//   readdata    registered read data, latency 1
//   irq         registered level interrupt request
// ---------------------------------------------------------------------------
module de0_nano_system_sense_i2c_data
  import de0_nano_system_sense_i2c_data_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int EDGE_TYPE       = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] filtered;
  logic [WIDTH-1:0] filtered_d;
  logic [WIDTH-1:0] edge_pulse;
  logic [WIDTH-1:0] clear_bits;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] irqmask;
  logic [31:0]      read_value;
  logic             write_en;
  logic             unused_writedata;

  // Only the low WIDTH bits of writedata carry register content.
  assign unused_writedata = ^writedata;

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_pin
      de0_nano_system_sense_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk      (clk),
        .reset_n  (reset_n),
        .pin      (in_port[i]),
        .filtered (filtered[i])
      );
    end
  endgenerate

  assign write_en = chipselect && !write_n;

  // Edge pulses come from comparing the filtered value with its one-cycle
  // delayed copy, so each accepted pin change yields exactly one pulse.
  always_comb begin
    edge_pulse = '0;
    if (EDGE_TYPE == EDGE_RISING) begin
      edge_pulse = filtered & ~filtered_d;
    end else if (EDGE_TYPE == EDGE_FALLING) begin
      edge_pulse = ~filtered & filtered_d;
    end else begin
      edge_pulse = filtered ^ filtered_d;
    end
  end

  always_comb begin
    clear_bits = '0;
    if (write_en && (address == ADDR_EDGECAP)) begin
      clear_bits = writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    read_value = '0;
    case (address)
      ADDR_DATA:    read_value[WIDTH-1:0] = filtered;
      ADDR_IRQMASK: read_value[WIDTH-1:0] = irqmask;
      ADDR_EDGECAP: read_value[WIDTH-1:0] = edgecapture;
      default:      read_value = '0;
    endcase
  end

  // The set term is ORed in after the clear so a pulse arriving in the same
  // cycle as a software clear is never lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filtered_d  <= '0;
      edgecapture <= '0;
    end else begin
      filtered_d  <= filtered;
      edgecapture <= (edgecapture & ~clear_bits) | edge_pulse;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask <= '0;
    end else if (write_en && (address == ADDR_IRQMASK)) begin
      irqmask <= writedata[WIDTH-1:0];
    end
  end

  // Read data and interrupt are both registered from current state, giving
  // one cycle of latency relative to the registers they reflect.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      readdata <= read_value;
      irq      <= |(edgecapture & irqmask);
    end
  end

endmodule

// File: tb/tb_de0_nano_system_sense_i2c_data.sv
// ---------------------------------------------------------------------------
// tb_de0_nano_system_sense_i2c_data
//
// Purpose:
//   Self-checking bench for the Avalon-MM parallel input port with
//   WIDTH = 4, EDGE_TYPE = any, DEBOUNCE_CYCLES = 16. Expected read values
//   are queued when a read is issued and compared when readdata is valid.
// ---------------------------------------------------------------------------
module tb_de0_nano_system_sense_i2c_data;
  import de0_nano_system_sense_i2c_data_pkg::*;

  localparam int WIDTH = 4;
  localparam int DEB   = 16;
  localparam int SETTLE = DEB + 9;

  logic             clk;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [WIDTH-1:0] in_port;
  logic [31:0]      readdata;
  logic             irq;

  int n_assert;
  int n_fail;
  logic [31:0] sb[$];
  logic [31:0] exp_val;

  de0_nano_system_sense_i2c_data #(
    .WIDTH           (WIDTH),
    .EDGE_TYPE       (EDGE_ANY),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Drives a read and queues its expected value; returns once readdata holds
  // the result of that read.
  task automatic issue_read(input logic [1:0] a, input logic [31:0] e);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b1;
    address    = a;
    sb.push_back(e);
    @(negedge clk);
    chipselect = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic test_reset();
    logic [1:0] addrs [4];
    addrs = '{ADDR_DATA, ADDR_RESERVED, ADDR_IRQMASK, ADDR_EDGECAP};
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      issue_read(addrs[k], 32'h0);
      exp_val = sb.pop_front();
      n_assert++;
      if (readdata !== exp_val) begin
        n_fail++;
        $display("[TB] FAIL reset_read addr=%0d: readdata=%h expected=%h", addrs[k], readdata, exp_val);
      end
    end
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_irq: irq=%b expected=0", irq);
    end
  endtask

  task automatic test_debounce();
    int first;
    // Glitch of 10 cycles must be rejected
    @(negedge clk);
    in_port[0] = 1'b1;
    repeat (10) @(negedge clk);
    in_port[0] = 1'b0;
    repeat (30) @(negedge clk);
    issue_read(ADDR_DATA, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL glitch_data: readdata=%h expected=%h", readdata, exp_val);
    end
    issue_read(ADDR_EDGECAP, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL glitch_edgecap: readdata=%h expected=%h", readdata, exp_val);
    end

    // A stable level is accepted after 2 sync + DEB filter cycles, visible
    // on readdata one cycle later.
    @(negedge clk);
    address    = ADDR_DATA;
    in_port[0] = 1'b1;
    first = -1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (first < 0 && readdata[0] === 1'b1) first = k;
    end
    n_assert++;
    if (first != DEB + 3) begin
      n_fail++;
      $display("[TB] FAIL debounce_latency: cycles=%0d expected=%0d", first, DEB + 3);
    end
    issue_read(ADDR_DATA, 32'h1);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL stable_data: readdata=%h expected=%h", readdata, exp_val);
    end
    issue_read(ADDR_EDGECAP, 32'h1);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL rise_edgecap: readdata=%h expected=%h", readdata, exp_val);
    end
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL masked_irq: irq=%b expected=0", irq);
    end
    bus_write(ADDR_EDGECAP, 32'h1);
    issue_read(ADDR_EDGECAP, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL w1c_clear: readdata=%h expected=%h", readdata, exp_val);
    end
  endtask

  task automatic test_irq_any_edge();
    logic levels [2];
    levels = '{1'b0, 1'b1};
    bus_write(ADDR_IRQMASK, 32'h1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      in_port[0] = levels[k];
      repeat (SETTLE) @(negedge clk);
      n_assert++;
      if (irq !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL edge%0d_irq_set: irq=%b expected=1", k, irq);
      end
      issue_read(ADDR_EDGECAP, 32'h1);
      exp_val = sb.pop_front();
      n_assert++;
      if (readdata !== exp_val) begin
        n_fail++;
        $display("[TB] FAIL edge%0d_edgecap: readdata=%h expected=%h", k, readdata, exp_val);
      end
      bus_write(ADDR_EDGECAP, 32'h1);
      n_assert++;
      if (irq !== 1'b1) begin
        n_fail++;
        $display("[TB] FAIL edge%0d_irq_hold: irq=%b expected=1", k, irq);
      end
      @(negedge clk);
      n_assert++;
      if (irq !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL edge%0d_irq_clear: irq=%b expected=0", k, irq);
      end
    end
    issue_read(ADDR_EDGECAP, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL irq_edgecap_cleared: readdata=%h expected=%h", readdata, exp_val);
    end
  endtask

  task automatic test_mask();
    bus_write(ADDR_IRQMASK, 32'h0);
    @(negedge clk);
    in_port[2] = 1'b1;
    repeat (SETTLE) @(negedge clk);
    issue_read(ADDR_EDGECAP, 32'h4);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL mask_edgecap: readdata=%h expected=%h", readdata, exp_val);
    end
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mask_irq_off: irq=%b expected=0", irq);
    end
    bus_write(ADDR_IRQMASK, 32'hFFFF_FFF4);
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mask_irq_early: irq=%b expected=0", irq);
    end
    @(negedge clk);
    n_assert++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL mask_irq_on: irq=%b expected=1", irq);
    end
    issue_read(ADDR_IRQMASK, 32'h4);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL mask_readback: readdata=%h expected=%h", readdata, exp_val);
    end
    bus_write(ADDR_EDGECAP, 32'h4);
    bus_write(ADDR_IRQMASK, 32'h0);
  endtask

  task automatic test_set_wins();
    @(negedge clk);
    address    = ADDR_EDGECAP;
    in_port[1] = 1'b1;
    // The edge pulse for bit 1 is live during the cycle after this point.
    repeat (DEB + 2) @(negedge clk);
    n_assert++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL setwins_precheck: readdata=%h expected=00000000", readdata);
    end
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = 32'h2;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    issue_read(ADDR_EDGECAP, 32'h2);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL set_wins: readdata=%h expected=%h", readdata, exp_val);
    end
    bus_write(ADDR_EDGECAP, 32'h2);
    issue_read(ADDR_EDGECAP, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL setwins_cleanup: readdata=%h expected=%h", readdata, exp_val);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    in_port = 4'b1000;
    repeat (SETTLE) @(negedge clk);
    bus_write(ADDR_IRQMASK, 32'hF);
    issue_read(ADDR_EDGECAP, 32'hF);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_edgecap: readdata=%h expected=%h", readdata, exp_val);
    end
    n_assert++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL pre_reset_irq: irq=%b expected=1", irq);
    end
    in_port = 4'b0111;
    repeat (8) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_irq: irq=%b expected=0", irq);
    end
    n_assert++;
    if (readdata !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL async_reset_readdata: readdata=%h expected=00000000", readdata);
    end
    @(negedge clk);
    reset_n = 1'b1;
    issue_read(ADDR_IRQMASK, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL post_reset_mask: readdata=%h expected=%h", readdata, exp_val);
    end
    issue_read(ADDR_EDGECAP, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL post_reset_edgecap: readdata=%h expected=%h", readdata, exp_val);
    end
    issue_read(ADDR_DATA, 32'h0);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL post_reset_data: readdata=%h expected=%h", readdata, exp_val);
    end
    // Pins held high through reset show up as fresh rising edges.
    repeat (SETTLE) @(negedge clk);
    issue_read(ADDR_DATA, 32'h7);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL post_reset_data_settled: readdata=%h expected=%h", readdata, exp_val);
    end
    issue_read(ADDR_EDGECAP, 32'h7);
    exp_val = sb.pop_front();
    n_assert++;
    if (readdata !== exp_val) begin
      n_fail++;
      $display("[TB] FAIL post_reset_rise_edges: readdata=%h expected=%h", readdata, exp_val);
    end
    n_assert++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL post_reset_irq: irq=%b expected=0", irq);
    end
  endtask

  initial begin
    n_assert   = 0;
    n_fail     = 0;
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = '0;

    test_reset();
    test_debounce();
    test_irq_any_edge();
    test_mask();
    test_set_wins();
    test_reset_mid();

    if (sb.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("[TB] FAIL scoreboard_leftover: entries=%0d expected=0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
